// File: rtl/sprite_layer_if.sv
// Sprite ROM / palette bus between sprite_layer (master) and the external
// index ROM plus combinational palette (slave).
interface sprite_layer_if #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (output rom_addr, pal_index,
                  input  rom_q, pal_red, pal_green, pal_blue);
  modport slave  (input  rom_addr, pal_index,
                  output rom_q, pal_red, pal_green, pal_blue);
endinterface

// File: rtl/sprite_layer.sv
// Single animated, integer-scaled sprite layer for the VGA path (3-edge pipeline).
// Optional mirroring via `define SPRITE_FLIP_EN (adds flip_x / flip_y ports).
module sprite_layer #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int NUM_FRAMES = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int ANIM_DIV   = 8,
  parameter int IDX_W      = 8,
  parameter int ADDR_W     = 12,
  parameter int TRANSP_IDX = 0,
  localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic            vga_clk,
  input  logic            reset,
  input  logic            frame_start,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            blank,
  input  logic [9:0]      pos_x,
  input  logic [9:0]      pos_y,
  input  logic            sprite_en,
`ifdef SPRITE_FLIP_EN
  input  logic            flip_x,
  input  logic            flip_y,
`endif
  sprite_layer_if.master  mem,
  output logic [3:0]      red,
  output logic [3:0]      green,
  output logic [3:0]      blue,
  output logic            hit,
  output logic [FI_W-1:0] frame_idx
);
  localparam int AC_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int BOX_W = SPR_W << SCALE_LOG2;
  localparam int BOX_H = SPR_H << SCALE_LOG2;

  logic [AC_W-1:0] anim_cnt;
  logic [9:0]      sx_s, sy_s;
  logic            en_s;
  logic [2:1]      vld_pipe;   // in_box delayed to line up with rom_q
  logic [2:1]      blk_pipe;

  // Shadow position/enable: sampled once per frame so a moving sprite never tears
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sx_s <= '0;
      sy_s <= '0;
      en_s <= 1'b0;
    end else if (frame_start) begin
      sx_s <= pos_x;
      sy_s <= pos_y;
      en_s <= sprite_en;
    end
  end

`ifdef SPRITE_FLIP_EN
  logic fx_s, fy_s;
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      fx_s <= 1'b0;
      fy_s <= 1'b0;
    end else if (frame_start) begin
      fx_s <= flip_x;
      fy_s <= flip_y;
    end
  end
`endif

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      anim_cnt  <= '0;
      frame_idx <= '0;
    end else if (frame_start) begin
      if (anim_cnt == AC_W'(ANIM_DIV - 1)) begin
        anim_cnt  <= '0;
        frame_idx <= (frame_idx == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  // S1: box test and address formation, all in 11 bits so sx+width never wraps
  logic [10:0] px, py, sx11, sy11, sx_end, sy_end, dx, dy, lx, ly, ax, ay;
  logic        in_box;

  assign px     = {1'b0, DrawX};
  assign py     = {1'b0, DrawY};
  assign sx11   = {1'b0, sx_s};
  assign sy11   = {1'b0, sy_s};
  assign sx_end = sx11 + 11'(BOX_W);
  assign sy_end = sy11 + 11'(BOX_H);
  assign dx     = px - sx11;
  assign dy     = py - sy11;
  assign lx     = dx >> SCALE_LOG2;
  assign ly     = dy >> SCALE_LOG2;
  assign in_box = en_s & (px >= sx11) & (px < sx_end) & (py >= sy11) & (py < sy_end);

`ifdef SPRITE_FLIP_EN
  assign ax = fx_s ? 11'(SPR_W - 1) - lx : lx;
  assign ay = fy_s ? 11'(SPR_H - 1) - ly : ly;
`else
  assign ax = lx;
  assign ay = ly;
`endif

  logic [ADDR_W-1:0] addr_nxt;
  assign addr_nxt = ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H)
                  + ADDR_W'(ay) * ADDR_W'(SPR_W) + ADDR_W'(ax);

  assign mem.pal_index = mem.rom_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      mem.rom_addr <= '0;
      vld_pipe     <= '0;
      blk_pipe     <= '0;
      hit          <= 1'b0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
    end else begin
      if (in_box) mem.rom_addr <= addr_nxt;
      vld_pipe <= {vld_pipe[1], in_box};
      blk_pipe <= {blk_pipe[1], blank};
      // S3: ROM data now matches the stage-2 flags
      if (blk_pipe[2] & vld_pipe[2] & (mem.rom_q != IDX_W'(TRANSP_IDX))) begin
        hit   <= 1'b1;
        red   <= mem.pal_red;
        green <= mem.pal_green;
        blue  <= mem.pal_blue;
      end else begin
        hit   <= 1'b0;
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench: instance a (scale 1x, ANIM_DIV 2), instance b (scale 2x, ANIM_DIV 8).
// ROM entry = {1,addr[6:0]} except address 5 which holds the transparent index 0.
module tb_sprite_layer;
  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = 10'd1000, DrawY = 10'd0;
  logic       blank = 1'b1;
  logic [9:0] pos_x = 10'd0, pos_y = 10'd0;
  logic       sprite_en = 1'b0;
`ifdef SPRITE_FLIP_EN
  logic       flip_x = 1'b0, flip_y = 1'b0;
`endif
  logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic       hit_a_o, hit_b_o;
  logic [1:0] frame_a, frame_b;

  int tests = 0;
  int fails = 0;

  logic [11:0] ca_a [0:127];
  logic [11:0] ca_b [0:127];
  logic        hit_a [0:127];
  logic        hit_b [0:127];
  logic [11:0] rgb_a [0:127];
  logic [11:0] rgb_b [0:127];

  always #5 vga_clk = ~vga_clk;

  sprite_layer_if ifa ();
  sprite_layer_if ifb ();

  sprite_layer #(.SCALE_LOG2(0), .ANIM_DIV(2)) dut_a (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .sprite_en(sprite_en),
`ifdef SPRITE_FLIP_EN
    .flip_x(flip_x), .flip_y(flip_y),
`endif
    .mem(ifa), .red(red_a), .green(green_a), .blue(blue_a),
    .hit(hit_a_o), .frame_idx(frame_a));

  sprite_layer #(.SCALE_LOG2(1), .ANIM_DIV(8)) dut_b (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .sprite_en(sprite_en),
`ifdef SPRITE_FLIP_EN
    .flip_x(flip_x), .flip_y(flip_y),
`endif
    .mem(ifb), .red(red_b), .green(green_b), .blue(blue_b),
    .hit(hit_b_o), .frame_idx(frame_b));

  function automatic logic [7:0] rom_f(input logic [11:0] a);
    return (a == 12'd5) ? 8'd0 : {1'b1, a[6:0]};
  endfunction

  always_ff @(posedge vga_clk) begin
    ifa.rom_q <= rom_f(ifa.rom_addr);
    ifb.rom_q <= rom_f(ifb.rom_addr);
  end
  assign ifa.pal_red   = ifa.pal_index[3:0];
  assign ifa.pal_green = ifa.pal_index[7:4];
  assign ifa.pal_blue  = ~ifa.pal_index[3:0];
  assign ifb.pal_red   = ifb.pal_index[3:0];
  assign ifb.pal_green = ifb.pal_index[7:4];
  assign ifb.pal_blue  = ~ifb.pal_index[3:0];

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; DrawX = 10'd1000; blank = 1'b1;
    repeat (2) @(negedge vga_clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input int x, input int y, input logic en);
    pos_x = 10'(x); pos_y = 10'(y); sprite_en = en;
    frame_start = 1'b1; DrawX = 10'd1000;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  // Stream n pixels along a row; capture per-pixel rom_addr and, two cycles later, hit/RGB
  task automatic scan(input int y, input int x0, input int n, input logic bl);
    for (int i = 0; i < n + 2; i++) begin
      DrawX = (i < n) ? 10'(x0 + i) : 10'd1000;
      DrawY = 10'(y); blank = bl;
      @(negedge vga_clk);
      if (i < n) begin ca_a[i] = ifa.rom_addr; ca_b[i] = ifb.rom_addr; end
      if (i >= 2) begin
        hit_a[i-2] = hit_a_o; rgb_a[i-2] = {red_a, green_a, blue_a};
        hit_b[i-2] = hit_b_o; rgb_b[i-2] = {red_b, green_b, blue_b};
      end
    end
    DrawX = 10'd1000; blank = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ifa.rom_addr !== 12'd0) begin fails++; $display("FAIL rst_addr got %0d want 0", ifa.rom_addr); end
    tests++; if ({hit_a_o, red_a, green_a, blue_a} !== 13'd0) begin fails++; $display("FAIL rst_out got %0h want 0", {hit_a_o, red_a, green_a, blue_a}); end
    pulse(0, 0, 1'b1);
    pulse(0, 0, 1'b1);
    tests++; if (frame_a !== 2'd1) begin fails++; $display("FAIL pre_rst_frame got %0d want 1", frame_a); end
    DrawX = 10'd3; DrawY = 10'd0;
    repeat (3) @(negedge vga_clk);
    tests++; if (hit_a_o !== 1'b1) begin fails++; $display("FAIL pre_rst_hit got %0b want 1", hit_a_o); end
    #3 reset = 1'b1;
    #1;
    tests++; if ({hit_a_o, red_a, green_a, blue_a} !== 13'd0) begin fails++; $display("FAIL async_rst_out got %0h want 0", {hit_a_o, red_a, green_a, blue_a}); end
    tests++; if (frame_a !== 2'd0) begin fails++; $display("FAIL async_rst_frame got %0d want 0", frame_a); end
    tests++; if (ifa.rom_addr !== 12'd0) begin fails++; $display("FAIL async_rst_addr got %0d want 0", ifa.rom_addr); end
    @(negedge vga_clk);
    reset = 1'b0;
    pulse(0, 0, 1'b1);
    DrawX = 10'd3; DrawY = 10'd0;
    @(negedge vga_clk);
    DrawX = 10'd1000;
    tests++; if (ifa.rom_addr !== 12'd3) begin fails++; $display("FAIL refill_addr got %0d want 3", ifa.rom_addr); end
    tests++; if (hit_a_o !== 1'b0) begin fails++; $display("FAIL refill_hit_e1 got %0b want 0", hit_a_o); end
    @(negedge vga_clk);
    tests++; if (hit_a_o !== 1'b0) begin fails++; $display("FAIL refill_hit_e2 got %0b want 0", hit_a_o); end
    @(negedge vga_clk);
    tests++; if ({hit_a_o, red_a, green_a, blue_a} !== 13'h138C) begin fails++; $display("FAIL refill_pix got %0h want 138c", {hit_a_o, red_a, green_a, blue_a}); end
  endtask

  task automatic test_placement();
    do_reset();
    pulse(100, 50, 1'b1);
    scan(50, 99, 35, 1'b1);
    tests++; if (hit_a[0] !== 1'b0) begin fails++; $display("FAIL place_x99_hit got %0b want 0", hit_a[0]); end
    tests++; if (ca_a[1] !== 12'd0) begin fails++; $display("FAIL place_x100_addr got %0d want 0", ca_a[1]); end
    tests++; if (hit_a[1] !== 1'b1 || rgb_a[1] !== 12'h08F) begin fails++; $display("FAIL place_x100_pix got %0b/%0h want 1/08f", hit_a[1], rgb_a[1]); end
    tests++; if (hit_a[6] !== 1'b0 || rgb_a[6] !== 12'h000) begin fails++; $display("FAIL place_transp got %0b/%0h want 0/000", hit_a[6], rgb_a[6]); end
    tests++; if (ca_a[32] !== 12'd31) begin fails++; $display("FAIL place_x131_addr got %0d want 31", ca_a[32]); end
    tests++; if (hit_a[32] !== 1'b1 || rgb_a[32] !== 12'hF90) begin fails++; $display("FAIL place_x131_pix got %0b/%0h want 1/f90", hit_a[32], rgb_a[32]); end
    tests++; if (hit_a[33] !== 1'b0 || ca_a[33] !== 12'd31) begin fails++; $display("FAIL place_x132 got %0b/%0d want 0/31", hit_a[33], ca_a[33]); end
    scan(49, 100, 1, 1'b1);
    tests++; if (hit_a[0] !== 1'b0) begin fails++; $display("FAIL place_y49 got %0b want 0", hit_a[0]); end
    scan(81, 100, 1, 1'b1);
    tests++; if (ca_a[0] !== 12'd992 || hit_a[0] !== 1'b1) begin fails++; $display("FAIL place_y81 got %0d/%0b want 992/1", ca_a[0], hit_a[0]); end
    scan(82, 100, 1, 1'b1);
    tests++; if (hit_a[0] !== 1'b0) begin fails++; $display("FAIL place_y82 got %0b want 0", hit_a[0]); end
  endtask

  task automatic test_scaling();
    do_reset();
    pulse(0, 0, 1'b1);
    scan(0, 0, 66, 1'b1);
    tests++; if (ca_b[0] !== 12'd0 || ca_b[1] !== 12'd0 || ca_b[2] !== 12'd1) begin fails++; $display("FAIL scale_x012 got %0d,%0d,%0d want 0,0,1", ca_b[0], ca_b[1], ca_b[2]); end
    tests++; if (hit_b[0] !== 1'b1 || rgb_b[0] !== 12'h08F) begin fails++; $display("FAIL scale_x0_pix got %0b/%0h want 1/08f", hit_b[0], rgb_b[0]); end
    tests++; if (ca_b[63] !== 12'd31 || hit_b[63] !== 1'b1) begin fails++; $display("FAIL scale_x63 got %0d/%0b want 31/1", ca_b[63], hit_b[63]); end
    tests++; if (ca_b[64] !== 12'd31 || hit_b[64] !== 1'b0) begin fails++; $display("FAIL scale_x64 got %0d/%0b want 31/0", ca_b[64], hit_b[64]); end
    tests++; if (hit_b[10] !== 1'b0 || rgb_b[10] !== 12'h000 || hit_b[11] !== 1'b0) begin fails++; $display("FAIL scale_transp got %0b/%0h/%0b want 0/000/0", hit_b[10], rgb_b[10], hit_b[11]); end
    tests++; if (hit_b[12] !== 1'b1 || rgb_b[12] !== 12'h689) begin fails++; $display("FAIL scale_x12_pix got %0b/%0h want 1/689", hit_b[12], rgb_b[12]); end
    scan(1, 0, 1, 1'b1);
    tests++; if (ca_b[0] !== 12'd0) begin fails++; $display("FAIL scale_y1 got %0d want 0", ca_b[0]); end
    scan(2, 0, 1, 1'b1);
    tests++; if (ca_b[0] !== 12'd32) begin fails++; $display("FAIL scale_y2 got %0d want 32", ca_b[0]); end
    scan(63, 63, 1, 1'b1);
    tests++; if (ca_b[0] !== 12'd1023) begin fails++; $display("FAIL scale_corner got %0d want 1023", ca_b[0]); end
    scan(64, 0, 1, 1'b1);
    tests++; if (hit_b[0] !== 1'b0) begin fails++; $display("FAIL scale_y64 got %0b want 0", hit_b[0]); end
  endtask

  task automatic test_animation();
    logic [1:0] exp_f [0:8];
    exp_f = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    for (int p = 0; p < 9; p++) begin
      tests++; if (frame_a !== exp_f[p]) begin fails++; $display("FAIL anim_frame%0d got %0d want %0d", p, frame_a, exp_f[p]); end
      if (p == 5) begin
        scan(0, 0, 1, 1'b1);
        tests++; if (ca_a[0] !== 12'd2048) begin fails++; $display("FAIL anim_addr got %0d want 2048", ca_a[0]); end
      end
      pulse(0, 0, 1'b1);
    end
    tests++; if (frame_b !== 2'd1) begin fails++; $display("FAIL anim_div8 got %0d want 1", frame_b); end
  endtask

  task automatic test_shadowing();
    do_reset();
    pulse(100, 50, 1'b1);
    pos_x = 10'd200;
    scan(50, 100, 2, 1'b1);
    tests++; if (ca_a[0] !== 12'd0 || ca_a[1] !== 12'd1 || hit_a[0] !== 1'b1) begin fails++; $display("FAIL shadow_hold got %0d,%0d/%0b want 0,1/1", ca_a[0], ca_a[1], hit_a[0]); end
    scan(50, 100, 2, 1'b0);
    tests++; if (hit_a[0] !== 1'b0 || rgb_a[0] !== 12'h000 || hit_a[1] !== 1'b0) begin fails++; $display("FAIL shadow_blank got %0b/%0h/%0b want 0/000/0", hit_a[0], rgb_a[0], hit_a[1]); end
    // pulse coincident with an in-box pixel: old position and old frame apply
    frame_start = 1'b1; DrawX = 10'd102; DrawY = 10'd50; blank = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0; DrawX = 10'd1000;
    tests++; if (ifa.rom_addr !== 12'd2 || frame_a !== 2'd1) begin fails++; $display("FAIL coincide_addr got %0d/%0d want 2/1", ifa.rom_addr, frame_a); end
    repeat (2) @(negedge vga_clk);
    tests++; if (hit_a_o !== 1'b1 || {red_a, green_a, blue_a} !== 12'h28D) begin fails++; $display("FAIL coincide_pix got %0b/%0h want 1/28d", hit_a_o, {red_a, green_a, blue_a}); end
    scan(50, 200, 1, 1'b1);
    tests++; if (ca_a[0] !== 12'd1024 || hit_a[0] !== 1'b1) begin fails++; $display("FAIL shadow_moved got %0d/%0b want 1024/1", ca_a[0], hit_a[0]); end
    scan(50, 100, 1, 1'b1);
    tests++; if (hit_a[0] !== 1'b0) begin fails++; $display("FAIL shadow_old_pos got %0b want 0", hit_a[0]); end
  endtask

`ifdef SPRITE_FLIP_EN
  task automatic test_flip();
    do_reset();
    flip_x = 1'b1; flip_y = 1'b0;
    pulse(0, 0, 1'b1);
    scan(0, 0, 1, 1'b1);
    tests++; if (ca_a[0] !== 12'd31) begin fails++; $display("FAIL flip_x got %0d want 31", ca_a[0]); end
    do_reset();
    flip_x = 1'b0; flip_y = 1'b1;
    pulse(0, 0, 1'b1);
    scan(0, 0, 1, 1'b1);
    tests++; if (ca_a[0] !== 12'd992) begin fails++; $display("FAIL flip_y got %0d want 992", ca_a[0]); end
    flip_y = 1'b0;
  endtask
`endif

  initial begin
    @(negedge vga_clk);
    test_reset();
    test_placement();
    test_scaling();
    test_animation();
    test_shadowing();
`ifdef SPRITE_FLIP_EN
    test_flip();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
